// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite definitions: transfer and size codes, response codes,
// the data-phase FSM state type and the transfer legality check.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Oversized transfers and misaligned halfword/word accesses are illegal.
    function automatic logic xfer_illegal(input logic [2:0] size, input logic [1:0] addr);
        logic bad;
        bad = 1'b0;
        if (size > HSIZE_WORD)                          bad = 1'b1;
        else if (size == HSIZE_HALF && addr[0])         bad = 1'b1;
        else if (size == HSIZE_WORD && addr != 2'b00)   bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between a master and one subordinate.
//   master modport: drives address/control/write data and HREADY
//   slave  modport: drives HREADYOUT, HRESP, HRDATA
interface ahb_lite_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_byte_strobe_gen.sv
// Little-endian byte-lane strobe decoder for 32-bit AHB data buses.
//   size : HSIZE code of the transfer
//   addr : low two address bits
//   strb : one bit per byte lane to be written (0 for illegal sizes)
module ahb_byte_strobe_gen
    import ahb_lite_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr,
    output logic [3:0] strb
);
    always_comb begin
        strb = 4'b0000;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << addr;
            HSIZE_HALF: strb = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: strb = 4'b1111;
            default:    strb = 4'b0000;
        endcase
    end
endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite subordinate with an internal word-organised RAM.
//   HCLK, HRESETn : clock and asynchronous active-low reset
//   bus           : AHB-Lite slave modport (select, address/control,
//                   write data, HREADY in; HREADYOUT, HRESP, HRDATA out)
// Each OKAY data phase lasts WAIT_STATES+1 cycles; illegal transfers get
// the two-cycle ERROR response. Back-to-back transfers are accepted in
// the completing cycle of the previous one.
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int MEM_AW      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_lite_sram_slave_if.slave bus
);
    state_t              state, state_n;
    logic [2:0]          wcnt, wcnt_n;
    logic [MEM_AW+1:0]   addr_q;
    logic                write_q;
    logic [2:0]          size_q;
    logic                accept, illegal, load, commit;
    logic                ready, resp;
    logic [3:0]          strb;
    logic [31:0]         mem [0:(1<<MEM_AW)-1];

    // Upper address bits alias; burst/protection/HTRANS[0] carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus.HBURST, bus.HPROT, bus.HADDR[31:MEM_AW+2], bus.HTRANS[0]};

    assign accept  = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign illegal = xfer_illegal(bus.HSIZE, bus.HADDR[1:0]);

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        load    = 1'b0;
        commit  = 1'b0;
        ready   = 1'b1;
        resp    = HRESP_OKAY;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_n = illegal ? ST_ERR1 : ST_DATA;
                    wcnt_n  = 3'(WAIT_STATES);
                end
            end
            ST_DATA: begin
                ready = (wcnt == 3'd0);
                if (wcnt != 3'd0) begin
                    wcnt_n = wcnt - 3'd1;
                end else begin
                    commit  = write_q;
                    state_n = ST_IDLE;
                    if (accept) begin
                        load    = 1'b1;
                        state_n = illegal ? ST_ERR1 : ST_DATA;
                        wcnt_n  = 3'(WAIT_STATES);
                    end
                end
            end
            ST_ERR1: begin
                ready   = 1'b0;
                resp    = HRESP_ERROR;
                state_n = ST_ERR2;
            end
            ST_ERR2: begin
                resp    = HRESP_ERROR;
                state_n = ST_IDLE;
                if (accept) begin
                    load    = 1'b1;
                    state_n = illegal ? ST_ERR1 : ST_DATA;
                    wcnt_n  = 3'(WAIT_STATES);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            wcnt    <= 3'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= HSIZE_BYTE;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            if (load) begin
                addr_q  <= bus.HADDR[MEM_AW+1:0];
                write_q <= bus.HWRITE;
                size_q  <= bus.HSIZE;
            end
        end
    end

    ahb_byte_strobe_gen u_strb (
        .size (size_q),
        .addr (addr_q[1:0]),
        .strb (strb)
    );

    // commit is derived from state, so a reset mid-phase (state forced to
    // IDLE) can never let a pending write through.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int j = 0; j < 4; j++) begin
                if (strb[j]) mem[addr_q[MEM_AW+1:2]][8*j +: 8] <= bus.HWDATA[8*j +: 8];
            end
        end
    end

    // Combinational read: a write committed at the edge that opens this
    // read's data phase is already visible, and data is stable all phase.
    assign bus.HRDATA    = (state == ST_DATA && !write_q) ? mem[addr_q[MEM_AW+1:2]] : 32'd0;
    assign bus.HREADYOUT = ready;
    assign bus.HRESP     = resp;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
module tb_ahb_lite_sram_slave;
    import ahb_lite_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'd0;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = HSIZE_WORD;
    logic [31:0] hwdata = 32'd0;
    int          dsel = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    logic        rdy, resp;
    logic [31:0] rdata;

    always #5 HCLK = ~HCLK;

    ahb_lite_sram_slave_if if0 ();
    ahb_lite_sram_slave_if if1 ();
    ahb_lite_sram_slave_if if2 ();

    // Each slave is alone on its bus, so HREADY is its own HREADYOUT.
    assign if0.HSEL = hsel && dsel == 0;
    assign if1.HSEL = hsel && dsel == 1;
    assign if2.HSEL = hsel && dsel == 2;
    assign {if0.HADDR, if0.HTRANS, if0.HWRITE, if0.HSIZE, if0.HWDATA} = {haddr, htrans, hwrite, hsize, hwdata};
    assign {if1.HADDR, if1.HTRANS, if1.HWRITE, if1.HSIZE, if1.HWDATA} = {haddr, htrans, hwrite, hsize, hwdata};
    assign {if2.HADDR, if2.HTRANS, if2.HWRITE, if2.HSIZE, if2.HWDATA} = {haddr, htrans, hwrite, hsize, hwdata};
    assign {if0.HBURST, if0.HPROT} = 7'd0;
    assign {if1.HBURST, if1.HPROT} = 7'd0;
    assign {if2.HBURST, if2.HPROT} = 7'd0;
    assign if0.HREADY = if0.HREADYOUT;
    assign if1.HREADY = if1.HREADYOUT;
    assign if2.HREADY = if2.HREADYOUT;

    ahb_lite_sram_slave #(.MEM_AW(10), .WAIT_STATES(0)) u_dut0 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if0));
    ahb_lite_sram_slave #(.MEM_AW(10), .WAIT_STATES(3)) u_dut1 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if1));
    ahb_lite_sram_slave #(.MEM_AW(10), .WAIT_STATES(5)) u_dut2 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if2));

    always_comb begin
        rdy = if0.HREADYOUT; resp = if0.HRESP; rdata = if0.HRDATA;
        case (dsel)
            1: begin rdy = if1.HREADYOUT; resp = if1.HRESP; rdata = if1.HRDATA; end
            2: begin rdy = if2.HREADYOUT; resp = if2.HRESP; rdata = if2.HRDATA; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_addr(input logic wr, input logic [2:0] sz, input logic [31:0] a);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = wr; hsize = sz; haddr = a;
    endtask

    task automatic idle_bus();
        hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    endtask

    // Waits (bounded) for HREADYOUT high; returns stall count and the
    // data/response seen in the ready cycle, then steps past the edge.
    task automatic wait_ready(input string tag, output int waits,
                              output logic [31:0] d, output logic r);
        waits = 0; d = 32'd0; r = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
            if (rdy) break;
            waits++;
        end
        if (!rdy) chk({tag, " timeout"}, {31'd0, rdy}, 32'd1);
        d = rdata; r = resp;
        @(posedge HCLK); #1;
    endtask

    task automatic do_write(input string tag, input logic [2:0] sz, input logic [31:0] a,
                            input logic [31:0] d, output int waits);
        logic [31:0] dd; logic rr; int w;
        drive_addr(1'b1, sz, a);
        wait_ready({tag, " aph"}, w, dd, rr);
        idle_bus();
        hwdata = d;
        wait_ready({tag, " dph"}, waits, dd, rr);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a,
                           output logic [31:0] d, output logic r, output int waits);
        logic [31:0] dd; logic rr; int w;
        drive_addr(1'b0, HSIZE_WORD, a);
        wait_ready({tag, " aph"}, w, dd, rr);
        idle_bus();
        wait_ready({tag, " dph"}, waits, d, r);
    endtask

    initial begin
        int          w;
        logic [31:0] d;
        logic        r;

        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst hreadyout", {31'd0, rdy}, 32'd1);
        chk("rst hresp", {31'd0, resp}, 32'd0);
        chk("rst hrdata", rdata, 32'd0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // ---- zero wait states ----
        dsel = 0;
        do_write("ws0 wr", HSIZE_WORD, 32'h10, 32'hDEADBEEF, w);
        chk("ws0 wr waits", 32'(w), 32'd0);
        do_read("ws0 rd", 32'h10, d, r, w);
        chk("ws0 rd data", d, 32'hDEADBEEF);
        chk("ws0 rd waits", 32'(w), 32'd0);
        chk("ws0 rd resp", {31'd0, r}, 32'd0);

        // Sub-word writes with junk in the unselected lanes.
        do_write("b0", HSIZE_BYTE, 32'h20, 32'hAAAAAA11, w);
        do_write("b1", HSIZE_BYTE, 32'h21, 32'hBBBB22BB, w);
        do_write("h2", HSIZE_HALF, 32'h22, 32'h4433CCCC, w);
        do_read("lanes rd", 32'h20, d, r, w);
        chk("lanes data", d, 32'h44332211);

        // Error response; word 0 must be untouched and a NONSEQ in ERR2 accepted.
        do_write("pre0", HSIZE_WORD, 32'h00, 32'hCAFEF00D, w);
        drive_addr(1'b1, HSIZE_HALF, 32'h03);
        @(posedge HCLK); #1;
        idle_bus();
        hwdata = 32'hFFFFFFFF;
        @(negedge HCLK);
        chk("err1 ready", {31'd0, rdy}, 32'd0);
        chk("err1 resp", {31'd0, resp}, 32'd1);
        @(posedge HCLK); #1;
        drive_addr(1'b0, HSIZE_WORD, 32'h00);
        @(negedge HCLK);
        chk("err2 ready", {31'd0, rdy}, 32'd1);
        chk("err2 resp", {31'd0, resp}, 32'd1);
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        chk("post err ready", {31'd0, rdy}, 32'd1);
        chk("post err resp", {31'd0, resp}, 32'd0);
        chk("post err data", rdata, 32'hCAFEF00D);
        @(posedge HCLK); #1;

        // Pipelined write then read of the same word.
        do_write("pre40", HSIZE_WORD, 32'h40, 32'h00000000, w);
        drive_addr(1'b1, HSIZE_WORD, 32'h40);
        @(posedge HCLK); #1;
        hwdata = 32'hA5A5A5A5;
        drive_addr(1'b0, HSIZE_WORD, 32'h40);
        @(negedge HCLK);
        chk("b2b wr ready", {31'd0, rdy}, 32'd1);
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        chk("b2b rd ready", {31'd0, rdy}, 32'd1);
        chk("b2b rd data", rdata, 32'hA5A5A5A5);
        @(posedge HCLK); #1;

        // BUSY, IDLE and unselected NONSEQ: zero-wait OKAY, no state change.
        hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h40;
        @(negedge HCLK);
        chk("busy ready", {31'd0, rdy}, 32'd1);
        chk("busy resp", {31'd0, resp}, 32'd0);
        @(posedge HCLK); #1;
        htrans = HTRANS_IDLE;
        @(negedge HCLK);
        chk("busy->idle data", rdata, 32'd0);
        @(posedge HCLK); #1;
        hsel = 1'b0; htrans = HTRANS_NONSEQ;
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        chk("unsel ready", {31'd0, rdy}, 32'd1);
        chk("unsel data", rdata, 32'd0);
        @(posedge HCLK); #1;

        // Address aliasing above the RAM size.
        do_write("alias wr", HSIZE_WORD, 32'h1010, 32'h13579BDF, w);
        do_read("alias rd", 32'h10, d, r, w);
        chk("alias data", d, 32'h13579BDF);

        // ---- three wait states ----
        dsel = 1;
        do_write("ws3 wr", HSIZE_WORD, 32'h10, 32'h0BADF00D, w);
        chk("ws3 wr waits", 32'(w), 32'd3);
        do_read("ws3 rd", 32'h10, d, r, w);
        chk("ws3 rd waits", 32'(w), 32'd3);
        chk("ws3 rd data", d, 32'h0BADF00D);

        // ---- five wait states, reset mid-write ----
        dsel = 2;
        do_write("ws5 pre", HSIZE_WORD, 32'h80, 32'hFFFF0000, w);
        chk("ws5 wr waits", 32'(w), 32'd5);
        drive_addr(1'b1, HSIZE_WORD, 32'h80);
        @(posedge HCLK); #1;
        idle_bus();
        hwdata = 32'h12345678;
        @(negedge HCLK);
        chk("ws5 stall", {31'd0, rdy}, 32'd0);
        @(posedge HCLK); #2;
        HRESETn = 1'b0;
        #1;
        chk("arst ready", {31'd0, rdy}, 32'd1);
        chk("arst resp", {31'd0, resp}, 32'd0);
        chk("arst data", rdata, 32'd0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        do_read("ws5 rd", 32'h80, d, r, w);
        chk("ws5 dropped wr", d, 32'hFFFF0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite responder: the subordinate end of the bus driven by the Cortex-M0 integration master.
- Contains an internal word-organised RAM, implemented as a register array.
- Supports programmable wait states, little-endian byte/halfword/word writes, and the two-cycle ERROR response.
- Sits behind the system address decoder. It is the default code/data memory for processor simulation and power analysis.

Parameters:
- MEM_AW, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KB).
- WAIT_STATES, 0, data-phase wait cycles per OKAY transfer. Legal range 0..7.

Ports:
- HCLK  input  1  single clock, all state on rising edge
- HRESETn  input  1  asynchronous active-low reset
- HSEL  input  1  slave select from address decoder
- HADDR  input  32  byte address; bits [MEM_AW+1:0] used
- HTRANS  input  2  IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
- HWRITE  input  1  1=write
- HSIZE  input  3  000 byte, 001 half, 010 word; others illegal
- HBURST  input  3  ignored; beats are treated independently
- HPROT  input  4  ignored
- HWDATA  input  32  write data, valid in data phase
- HREADY  input  1  bus-level ready (previous transfer complete)
- HREADYOUT  output  1  this slave's ready
- HRESP  output  1  0=OKAY 1=ERROR
- HRDATA  output  32  read data

Behaviour:
- Accept condition: HSEL & HTRANS[1] & HREADY at a rising edge. On accept, latch addr_q=HADDR[MEM_AW+1:0], write_q, size_q.
- BUSY, IDLE, or unselected transfers get a zero-wait OKAY. No state change.
- Illegal transfer: HSIZE>010, halfword with HADDR[0]=1, or word with HADDR[1:0]!=00.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0. RAM contents are not reset.
- FSM states:
  - IDLE → DATA on legal accept; wcnt loaded with WAIT_STATES.
  - IDLE → ERR1 on illegal accept.
  - DATA: HREADYOUT=(wcnt==0), HRESP=0. Decrement wcnt while nonzero. When wcnt==0, the cycle completes.
  - ERR1: HREADYOUT=0, HRESP=1. Always → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1.
  - Completion of DATA or ERR2: next state = DATA/ERR1 if a new accept occurs in the same cycle (pipelined back-to-back), else IDLE.
- Latency: with WAIT_STATES=N, a read or write data phase lasts N+1 cycles. Back-to-back transfers sustain 1 transfer per N+1 cycles.
- Write commit:
  - Occurs at the rising edge ending the completing DATA cycle (HREADYOUT=1).
  - Byte lane j written with HWDATA[8j+7:8j] where strobe[j]=1. Strobe decoding:
    - byte: lane addr_q[1:0]
    - half: lanes {addr_q[1],0} and {addr_q[1],1}
    - word: all lanes
  - An aborted data phase (reset) never commits.
- Read data:
  - HRDATA = full word mem[addr_q[MEM_AW+1:2]] during a read DATA state, regardless of size. The master selects the lanes.
  - HRDATA=0 in all other states.
  - Must be stable on every cycle while HREADYOUT=1 in DATA.
- Read-after-write to the same word, back-to-back: the read's data phase returns the newly written value, because the write commits before the read's data phase.
- Address wrap: bits above MEM_AW+1 are ignored, so the RAM aliases across the HSEL region.
- Address phase presented while HREADY=0 (this or another slave stalling) is not sampled. The master holds or, during ERR1, may change it to IDLE.
- Asynchronous reset mid-operation: immediately returns to IDLE with HREADYOUT=1, HRESP=0. The pending write is dropped.

Decomposition:
- Package ahb_lite_pkg:
  - HTRANS codes
  - HSIZE codes (BYTE/HALF/WORD)
  - HRESP_OKAY/HRESP_ERROR
  - FSM state enum {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2}
  - illegal-size/alignment check function
- Sub-module ahb_byte_strobe_gen: combinational (size, addr[1:0]) → 4-bit lane strobe. Reused by future AHB peripherals.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 → HREADYOUT stays 1; HRDATA=0xDEADBEEF in the read data phase; HRESP=0.
- Byte writes 0x11@0x20, 0x22@0x21, half 0x4433@0x22, then word read @0x20 → HRDATA=0x44332211.
- WAIT_STATES=3: single read → HREADYOUT low for exactly 3 cycles, high on the 4th; write commits only after the 4th cycle.
- Half write @0x03 → ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); RAM word @0x00 unchanged; a following legal NONSEQ is accepted in ERR2.
- Pipelined: write 0xA5A5A5A5 @0x40 immediately followed by read @0x40 with WAIT_STATES=0 → read returns 0xA5A5A5A5. A BUSY/IDLE interleave → zero-wait OKAY.
- WAIT_STATES=5: assert HRESETn=0 during the 2nd wait cycle of write 0x12345678 @0x80 → outputs at reset values immediately; later read @0x80 ≠ 0x12345678 (prior value retained).
